// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the configurable UART transmitter
// and its companion receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    idle   = 3'd0,
    start  = 3'd1,
    data   = 3'd2,
    parity = 3'd3,
    stop   = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    par_none = 2'b00,
    par_even = 2'b01,
    par_odd  = 2'b10
  } parity_t;

  localparam int min_data_bits = 5;
  localparam int max_data_bits = 9;
  localparam int min_div       = 2;

  // Force the requested data-bit count into the supported 5..9 range.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits);
    logic [3:0] res;
    if (bits < 4'(min_data_bits)) begin
      res = 4'(min_data_bits);
    end else if (bits > 4'(max_data_bits)) begin
      res = 4'(max_data_bits);
    end else begin
      res = bits;
    end
    return res;
  endfunction

  // The unused encoding 2'b11 falls back to no parity.
  function automatic parity_t decode_parity(input logic [1:0] code);
    parity_t res;
    case (code)
      2'b01:   res = par_even;
      2'b10:   res = par_odd;
      default: res = par_none;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready word stream feeding the transmitter FIFO.
interface uart_tx_cfg_if #(
  parameter int data_w_max = 9
) ();
  logic                  s_valid;
  logic [data_w_max-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; full/empty come straight from
// the registered pointers so they are glitch-free.
module uart_sync_fifo #(
  parameter int width = 9,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = (aw + 1)'(1);

  logic [aw:0]      wr_ptr_r;
  logic [aw:0]      rd_ptr_r;
  logic [width-1:0] mem_r [depth];

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[aw] != rd_ptr_r[aw]) &&
                 (wr_ptr_r[aw-1:0] == rd_ptr_r[aw-1:0]);
  assign rdata = mem_r[rd_ptr_r[aw-1:0]];

  // Advance the pointers on accepted pushes and pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr_r <= wr_ptr_r + ptr_one;
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + ptr_one;
      end
    end
  end

  // Storage write; contents need no reset because empty guards the read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[wr_ptr_r[aw-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame data bits, parity, stop bits and baud
// divisor, fed by a small word FIFO.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int div_w      = 16,
  parameter int fifo_depth = 4,
  parameter int data_w_max = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [div_w-1:0]  cfg_div,
  input  logic [3:0]        cfg_data_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_two_stop,
  uart_tx_cfg_if.slave      s_if,
  output logic              tx,
  output logic              tx_busy
);
  localparam logic [div_w-1:0] cnt_one = div_w'(1);

  logic [data_w_max-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  tx_state_t             state_r;
  logic [data_w_max-1:0] word_r;
  logic [div_w-1:0]      div_r;
  logic [3:0]            nbits_r;
  parity_t               par_r;
  logic                  two_stop_r;
  logic [div_w-1:0]      cnt_r;
  logic [3:0]            bit_idx_r;
  logic                  stop_idx_r;
  logic                  tx_r;
  logic                  busy_r;

  logic [div_w-1:0]      div_clamped_s;
  logic                  bit_end_s;

  // Parity over the low n bits only; odd parity starts from 1.
  function automatic logic frame_parity(input logic [data_w_max-1:0] w,
                                        input logic [3:0] n,
                                        input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < data_w_max; i++) begin
      if (i < int'(n)) begin
        p = p ^ w[i];
      end
    end
    return p;
  endfunction

  assign div_clamped_s = (cfg_div < div_w'(min_div)) ? div_w'(min_div) : cfg_div;
  assign bit_end_s     = (cnt_r == div_r - cnt_one);
  assign fifo_pop      = (state_r == idle) && !fifo_empty;
  assign s_if.s_ready  = !fifo_full;
  assign tx            = tx_r;
  assign tx_busy       = busy_r;

  uart_sync_fifo #(
    .width (data_w_max),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_if.s_valid),
    .wdata (s_if.s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame sequencer: latches a word plus config, then shifts out bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= idle;
      word_r     <= '0;
      div_r      <= div_w'(min_div);
      nbits_r    <= 4'(min_data_bits);
      par_r      <= par_none;
      two_stop_r <= 1'b0;
      cnt_r      <= '0;
      bit_idx_r  <= 4'd0;
      stop_idx_r <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        idle: begin
          if (!fifo_empty) begin
            word_r     <= fifo_rdata;
            div_r      <= div_clamped_s;
            nbits_r    <= clamp_data_bits(cfg_data_bits);
            par_r      <= decode_parity(cfg_parity);
            two_stop_r <= cfg_two_stop;
            cnt_r      <= '0;
            bit_idx_r  <= 4'd0;
            stop_idx_r <= 1'b0;
            tx_r       <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= start;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        start: begin
          if (bit_end_s) begin
            cnt_r   <= '0;
            tx_r    <= word_r[0];
            state_r <= data;
          end else begin
            cnt_r <= cnt_r + cnt_one;
          end
        end
        data: begin
          if (bit_end_s) begin
            cnt_r <= '0;
            if (bit_idx_r == nbits_r - 4'd1) begin
              if (par_r != par_none) begin
                tx_r    <= frame_parity(word_r, nbits_r, par_r == par_odd);
                state_r <= parity;
              end else begin
                tx_r    <= 1'b1;
                state_r <= stop;
              end
            end else begin
              bit_idx_r <= bit_idx_r + 4'd1;
              tx_r      <= word_r[bit_idx_r + 4'd1];
            end
          end else begin
            cnt_r <= cnt_r + cnt_one;
          end
        end
        parity: begin
          if (bit_end_s) begin
            cnt_r   <= '0;
            tx_r    <= 1'b1;
            state_r <= stop;
          end else begin
            cnt_r <= cnt_r + cnt_one;
          end
        end
        stop: begin
          if (bit_end_s) begin
            cnt_r <= '0;
            tx_r  <= 1'b1;
            if (two_stop_r && !stop_idx_r) begin
              stop_idx_r <= 1'b1;
            end else begin
              // Busy only stays up across the idle gap if work is queued.
              busy_r  <= !fifo_empty;
              state_r <= idle;
            end
          end else begin
            cnt_r <= cnt_r + cnt_one;
          end
        end
        default: begin
          state_r <= idle;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
